bfp_to_bf16_core: RTL and testbench



---
 rtl/bfp_to_bf16_core.sv | 223 ++++++++++++++++++++++
 tb/tb_bfp_to_bf16_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_to_bf16_core.sv
// -----------------------------------------------------------------------------
// bfp_to_bf16_core
//
// Converts one block-floating-point block (a shared exponent plus NUM signed
// two's-complement mantissas) into NUM independent sign/exponent/mantissa
// triples with a normalized mantissa (MSB is the hidden bit).
//
// Pipeline (4 registered stages, all advance together on ready_out):
//   1. register inputs, split sign and magnitude
//   2. leading-zero count of the magnitude
//   3. normalize mantissa, compute signed unbiased exponent
//   4. zero / flush-to-zero / overflow handling, registered outputs
//
// Build option:
//   BFP_TO_BF16_SAT_EN  defined   -> exponent overflow saturates to the
//                                    largest finite exponent, mantissa all ones
//                       undefined -> exponent overflow wraps modulo 2^E
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   valid_in / ready_out upstream handshake (ready_out = !valid_out || ready_in)
//   shared_exponent_in   shared block exponent (EXPONENT_SIZE bits)
//   sdata_in[0:NUM-1]    signed mantissas (MANTISSA_SIZE bits)
//   valid_out / ready_in downstream handshake
//   sign_out, exponent_out, mantissa_out [0:NUM-1]  converted elements
// -----------------------------------------------------------------------------
module bfp_to_bf16_core #(
    parameter int NUM           = 10,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 8,
    parameter int NX_MODE       = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  logic [EXPONENT_SIZE-1:0]        shared_exponent_in,
    input  logic signed [MANTISSA_SIZE-1:0] sdata_in [0:NUM-1],
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic                            sign_out [0:NUM-1],
    output logic [EXPONENT_SIZE-1:0]        exponent_out [0:NUM-1],
    output logic [MANTISSA_SIZE-1:0]        mantissa_out [0:NUM-1]
);

    localparam int E   = EXPONENT_SIZE;
    localparam int M   = MANTISSA_SIZE;
    localparam int EW  = EXPONENT_SIZE + 2;
    localparam int LZW = $clog2(MANTISSA_SIZE + 1);

    // NX-style shared exponents carry an extra -6 bias on top of the +1
    // that moves the binary point from below the sign bit to the hidden bit.
    localparam logic signed [EW-1:0] ADJ    = (NX_MODE == 1) ? EW'(32'sd7) : EW'(32'sd1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((32'sd1 <<< EXPONENT_SIZE) - 32'sd2);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic [E-1:0]         E_SAT  = E_MAX[E-1:0];

    // Magnitude of a two's-complement value; the most negative value maps to
    // 2^(M-1), which still fits in M unsigned bits.
    function automatic logic [M-1:0] abs_mag(input logic [M-1:0] d);
        logic [M-1:0] r;
        if (d[M-1]) begin
            r = ~d + M'(1);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Leading-zero count over M bits; an all-zero value returns M.
    function automatic logic [LZW-1:0] count_lz(input logic [M-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LZW'(1);
                end
            end
        end
        return n;
    endfunction

    logic advance_s;

    // stage 1
    logic           v1_r;
    logic [E-1:0]   sexp1_r;
    logic           sign1_r [0:NUM-1];
    logic [M-1:0]   mag1_r  [0:NUM-1];
    // stage 2
    logic           v2_r;
    logic [E-1:0]   sexp2_r;
    logic           sign2_r [0:NUM-1];
    logic [M-1:0]   mag2_r  [0:NUM-1];
    logic [LZW-1:0] lz2_r   [0:NUM-1];
    // stage 3
    logic                 v3_r;
    logic                 sign3_r [0:NUM-1];
    logic [M-1:0]         mant3_r [0:NUM-1];
    logic signed [EW-1:0] e3_r    [0:NUM-1];
    // stage 4 next values
    logic           sign_n [0:NUM-1];
    logic [E-1:0]   exp_n  [0:NUM-1];
    logic [M-1:0]   mant_n [0:NUM-1];

    // A stall at the output freezes the whole pipeline.
    assign advance_s = !valid_out || ready_in;
    assign ready_out = advance_s;

    // Stage 1: capture block, split sign and magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            sexp1_r <= '0;
            for (int i = 0; i < NUM; i++) begin
                sign1_r[i] <= 1'b0;
                mag1_r[i]  <= '0;
            end
        end else if (advance_s) begin
            v1_r    <= valid_in;
            sexp1_r <= shared_exponent_in;
            for (int i = 0; i < NUM; i++) begin
                sign1_r[i] <= sdata_in[i][M-1];
                mag1_r[i]  <= abs_mag(sdata_in[i]);
            end
        end
    end

    // Stage 2: leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            sexp2_r <= '0;
            for (int i = 0; i < NUM; i++) begin
                sign2_r[i] <= 1'b0;
                mag2_r[i]  <= '0;
                lz2_r[i]   <= '0;
            end
        end else if (advance_s) begin
            v2_r    <= v1_r;
            sexp2_r <= sexp1_r;
            for (int i = 0; i < NUM; i++) begin
                sign2_r[i] <= sign1_r[i];
                mag2_r[i]  <= mag1_r[i];
                lz2_r[i]   <= count_lz(mag1_r[i]);
            end
        end
    end

    // Stage 3: normalize and compute the per-element signed exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                sign3_r[i] <= 1'b0;
                mant3_r[i] <= '0;
                e3_r[i]    <= '0;
            end
        end else if (advance_s) begin
            v3_r <= v2_r;
            for (int i = 0; i < NUM; i++) begin
                sign3_r[i] <= sign2_r[i];
                mant3_r[i] <= mag2_r[i] << lz2_r[i];
                e3_r[i]    <= $signed({2'b00, sexp2_r}) + ADJ
                              - $signed({{(EW - LZW){1'b0}}, lz2_r[i]});
            end
        end
    end

    // Stage 4 next values: zero, flush-to-zero and overflow handling.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            sign_n[i] = 1'b0;
            exp_n[i]  = '0;
            mant_n[i] = '0;
            // A zero mantissa after normalization means the magnitude was zero.
            if ((mant3_r[i] == '0) || (e3_r[i] <= E_ZERO)) begin
                sign_n[i] = 1'b0;
                exp_n[i]  = '0;
                mant_n[i] = '0;
            end else if (e3_r[i] > E_MAX) begin
`ifdef BFP_TO_BF16_SAT_EN
                sign_n[i] = sign3_r[i];
                exp_n[i]  = E_SAT;
                mant_n[i] = '1;
`else
                sign_n[i] = sign3_r[i];
                exp_n[i]  = e3_r[i][E-1:0];
                mant_n[i] = mant3_r[i];
`endif
            end else begin
                sign_n[i] = sign3_r[i];
                exp_n[i]  = e3_r[i][E-1:0];
                mant_n[i] = mant3_r[i];
            end
        end
    end

    // Stage 4: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                sign_out[i]     <= 1'b0;
                exponent_out[i] <= '0;
                mantissa_out[i] <= '0;
            end
        end else if (advance_s) begin
            valid_out <= v3_r;
            for (int i = 0; i < NUM; i++) begin
                sign_out[i]     <= sign_n[i];
                exponent_out[i] <= exp_n[i];
                mantissa_out[i] <= mant_n[i];
            end
        end
    end

endmodule

// File: tb/tb_bfp_to_bf16_core.sv
// -----------------------------------------------------------------------------
// tb_bfp_to_bf16_core
//
// Directed self-checking bench for bfp_to_bf16_core with default parameters
// (NUM=10, E=8, M=8, NX_MODE=1). Inputs are driven and outputs sampled on the
// falling clock edge. Expected values are hand-computed; overflow expectations
// follow BFP_TO_BF16_SAT_EN when the bench is built with that macro.
// -----------------------------------------------------------------------------
module tb_bfp_to_bf16_core;

    localparam int NUM = 10;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic              ready_out;
    logic [7:0]        shared_exponent_in;
    logic signed [7:0] sdata_in [0:NUM-1];
    logic              valid_out;
    logic              ready_in;
    logic              sign_out [0:NUM-1];
    logic [7:0]        exponent_out [0:NUM-1];
    logic [7:0]        mantissa_out [0:NUM-1];

    int checks;
    int errors;

    // current directed block and its expected conversion
    logic [7:0] blk_shared;
    logic [7:0] blk_data [0:NUM-1];
    logic       exp_sign [0:NUM-1];
    logic [7:0] exp_exp  [0:NUM-1];
    logic [7:0] exp_mant [0:NUM-1];

    bfp_to_bf16_core #(
        .NUM(10), .EXPONENT_SIZE(8), .MANTISSA_SIZE(8), .NX_MODE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .shared_exponent_in(shared_exponent_in), .sdata_in(sdata_in),
        .valid_out(valid_out), .ready_in(ready_in), .sign_out(sign_out),
        .exponent_out(exponent_out), .mantissa_out(mantissa_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Send the current block as a single transfer and wait (bounded) for it.
    task automatic run_single(output int lat);
        @(negedge clk);
        ready_in           = 1'b1;
        shared_exponent_in = blk_shared;
        for (int j = 0; j < NUM; j++) sdata_in[j] = blk_data[j];
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        shared_exponent_in = 8'd0;
        for (int j = 0; j < NUM; j++) sdata_in[j] = 8'sd0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", valid_out);
        end
        for (int j = 0; j < NUM; j++) begin
            checks++;
            if (sign_out[j] !== 1'b0 || exponent_out[j] !== 8'd0 || mantissa_out[j] !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got s=%b e=%0d m=%h expected 0", j,
                         sign_out[j], exponent_out[j], mantissa_out[j]);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", ready_out);
        end
    endtask

    task automatic check_block(input string name, input int lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL %s_latency: got %0d expected 4", name, lat);
        end
        for (int j = 0; j < NUM; j++) begin
            checks++;
            if (sign_out[j] !== exp_sign[j] || exponent_out[j] !== exp_exp[j] ||
                mantissa_out[j] !== exp_mant[j]) begin
                errors++;
                $display("FAIL %s[%0d]: got s=%b e=%0d m=%h expected s=%b e=%0d m=%h",
                         name, j, sign_out[j], exponent_out[j], mantissa_out[j],
                         exp_sign[j], exp_exp[j], exp_mant[j]);
            end
        end
    endtask

    task automatic test_basic;
        int lat;
        blk_shared = 8'd120;
        blk_data = '{8'h40, 8'hC0, 8'h01, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h20, 8'h03, 8'h81};
        exp_sign = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_exp  = '{8'd126, 8'd126, 8'd120, 8'd127, 8'd0, 8'd126, 8'd120, 8'd125, 8'd121, 8'd126};
        exp_mant = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'hFE, 8'h80, 8'h80, 8'hC0, 8'hFE};
        run_single(lat);
        check_block("basic", lat);
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got valid_out=%b expected 0", valid_out);
        end
    endtask

    task automatic test_flush;
        int lat;
        blk_shared = 8'd0;
        blk_data = '{8'h01, 8'h02, 8'hFF, 8'h00, 8'h40, 8'h80, 8'h7F, 8'hFE, 8'h10, 8'h04};
        exp_sign = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_exp  = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd6, 8'd7, 8'd6, 8'd1, 8'd4, 8'd2};
        exp_mant = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h80, 8'hFE, 8'h80, 8'h80, 8'h80};
        run_single(lat);
        check_block("flush", lat);
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int lat;
        blk_shared = 8'd250;
        blk_data = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h01, 8'h02, 8'h00, 8'hC0, 8'hE0, 8'hF0};
        exp_sign = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef BFP_TO_BF16_SAT_EN
        exp_exp  = '{8'd254, 8'd254, 8'd254, 8'd254, 8'd250, 8'd251, 8'd0, 8'd254, 8'd254, 8'd254};
        exp_mant = '{8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h80};
`else
        exp_exp  = '{8'd1, 8'd0, 8'd255, 8'd254, 8'd250, 8'd251, 8'd0, 8'd0, 8'd255, 8'd254};
        exp_mant = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80, 8'h80};
`endif
        run_single(lat);
        check_block("overflow", lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int tx;
        int rx;
        tx = 0; rx = 0;
        valid_in = 1'b0; ready_in = 1'b1;
        for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
            @(negedge clk);
            ready_in = !(cyc >= 5 && cyc <= 7);
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                checks++;
                if (valid_out !== 1'b1 || ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stall cyc%0d: got valid_out=%b ready_out=%b expected 1 0",
                             cyc, valid_out, ready_out);
                end
            end
            if (valid_out) begin
                for (int j = 0; j < NUM; j++) begin
                    checks++;
                    if (sign_out[j] !== 1'b0 || exponent_out[j] !== 8'(106 + rx) ||
                        mantissa_out[j] !== 8'h80) begin
                        errors++;
                        $display("FAIL b2b_block%0d[%0d]: got s=%b e=%0d m=%h expected s=0 e=%0d m=80",
                                 rx, j, sign_out[j], exponent_out[j], mantissa_out[j], 106 + rx);
                    end
                end
                if (ready_in) rx++;
            end
            if (tx < 6) begin
                valid_in = 1'b1;
                shared_exponent_in = 8'(100 + tx);
                for (int j = 0; j < NUM; j++) sdata_in[j] = 8'sh40;
                if (ready_out) tx++;
            end else begin
                valid_in = 1'b0;
            end
        end
        checks++;
        if (rx !== 6) begin
            errors++; $display("FAIL b2b_count: got %0d blocks expected 6", rx);
        end
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got valid_out=%b expected 0", valid_out);
        end
    endtask

    task automatic test_reset_midflight;
        int lat;
        logic stale;
        ready_in = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            valid_in = 1'b1;
            shared_exponent_in = 8'(100 + b);
            for (int j = 0; j < NUM; j++) sdata_in[j] = 8'sh40;
        end
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got valid_out=%b expected 1", valid_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || exponent_out[0] !== 8'd0 || mantissa_out[0] !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got valid_out=%b e=%0d m=%h expected 0 0 0",
                     valid_out, exponent_out[0], mantissa_out[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready_out);
        end
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (valid_out !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stale: got stale=%b expected 0", stale);
        end
        blk_shared = 8'd120;
        blk_data = '{8'h40, 8'hC0, 8'h01, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h20, 8'h03, 8'h81};
        exp_sign = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_exp  = '{8'd126, 8'd126, 8'd120, 8'd127, 8'd0, 8'd126, 8'd120, 8'd125, 8'd121, 8'd126};
        exp_mant = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'hFE, 8'h80, 8'h80, 8'hC0, 8'hFE};
        run_single(lat);
        check_block("rst_mid_next", lat);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
